microsequencer_stack: RTL and testbench
=======================================

Name: microsequencer_stack

Overview:
- Parametrised next-address sequencer for the microprogrammed control unit.
- Holds the registered micro-program counter (uPC) that addresses the Microstore.
- Each cycle it selects the next address from: increment, microword jump field, instruction-decode address, conditional branch, or a hardware call/return stack.
- Successor to the fixed 9-bit NSAM/NSAS/Inverter/Condition_MUX cluster. Adds width/condition-count parameters, microsubroutine call/return, a stall input and error flags.

Parameters:
- AW, 9, micro-address width in bits.
- NUM_COND, 4, number of condition inputs (MOC, Cond, IR[29], Trap by default).
- CSW, 2, width of the condition select; must satisfy 2**CSW >= NUM_COND.
- STACK_DEPTH, 4, return-stack entries (1..16).
- RESET_ADDR, 0, uPC value after reset and the target on stack underflow.

Ports:
- Clock  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high reset.
- NS_Ctrl  in  3  next-state mode, from the Control_Register feedback field.
- CR_Addr  in  AW  jump/call target from the microword.
- Decode_Addr  in  AW  address from the instruction decoder/encoder.
- Cond_In  in  NUM_COND  raw condition inputs.
- Cond_Sel  in  CSW  selects one bit of Cond_In.
- Invert  in  1  inverts the selected condition.
- Stall  in  1  freezes the sequencer for this cycle.
- uPC  out  AW  current micro-address, registered.
- Stack_Depth  out  5  number of valid stack entries.
- Stack_Overflow  out  1  sticky error flag.
- Stack_Underflow  out  1  sticky error flag.

Behaviour:
- Everything updates on the rising edge of Clock. Inputs are sampled at the edge; the new uPC is visible after that edge, i.e. one-cycle latency from NS_Ctrl to uPC.
- Reset is synchronous, highest priority, and overrides Stall. Reset values:
  - uPC = RESET_ADDR
  - Stack_Depth = 0
  - Stack_Overflow = 0
  - Stack_Underflow = 0
  - stack contents are don't-care
- Reset asserted mid-subroutine discards all stack entries.
- C (effective condition) = Cond_In[Cond_Sel] XOR Invert. If Cond_Sel >= NUM_COND, the selected bit is 0 before inversion.
- INC = (uPC + 1) mod 2**AW. The last address wraps to 0 with no flag.
- NS_Ctrl modes:
  - 0 INC: uPC <= INC.
  - 1 JUMP: uPC <= CR_Addr.
  - 2 DECODE: uPC <= Decode_Addr.
  - 3 CBR: uPC <= C ? CR_Addr : INC.
  - 4 CWAIT: uPC <= C ? INC : uPC (hold, e.g. waiting on MOC).
  - 5 CALL: push INC; uPC <= CR_Addr.
  - 6 CCALL: if C, act as CALL; else uPC <= INC with no push.
  - 7 RET: pop; uPC <= popped entry.
- Stack is LIFO. Push writes entry[Stack_Depth] and increments the depth; pop reads entry[Stack_Depth-1] and decrements it.
- Overflow: CALL, or CCALL with C=1, while Stack_Depth == STACK_DEPTH. The jump to CR_Addr still occurs, the push is dropped, the depth is unchanged and Stack_Overflow is set.
- Underflow: RET while Stack_Depth == 0. uPC <= RESET_ADDR, the depth stays 0 and Stack_Underflow is set.
- Both error flags are sticky until Reset.
- Stall = 1 (and Reset = 0): uPC, the stack, the depth and the flags all hold. NS_Ctrl is ignored, so no push or pop happens.
- There are no simultaneous push/pop cases; each mode performs at most one stack operation per cycle.

Test Plan:
1. Reset, then 3 cycles of NS_Ctrl=0 -> uPC sequence 0,1,2,3; hold uPC=511 with INC -> next uPC = 0.
2. uPC=10, NS_Ctrl=3, Cond_Sel=1, Cond_In=4'b0010, Invert=0, CR_Addr=200 -> uPC=200. Repeat with Invert=1 -> uPC=11.
3. NS_Ctrl=4, Cond_Sel=0 (MOC), Cond_In[0]=0 for 3 cycles then 1 -> uPC held at 50 for 3 cycles, then 51.
4. From uPC=20, CALL CR_Addr=100 -> uPC=100, depth=1. INC twice, then RET -> uPC=21, depth=0.
5. Five nested CALLs (STACK_DEPTH=4) -> after the 5th: depth=4, Stack_Overflow=1, uPC=CR_Addr. Five RETs -> first four return the correct addresses; the 5th gives uPC=0 and Stack_Underflow=1.
6. Stall=1 during a CALL -> uPC and depth unchanged. Reset asserted together with Stall at depth=2 -> uPC=0, depth=0, both flags 0.

Source files
------------

// File: rtl/microsequencer_stack_if.sv
// Sequencer bus: next-state control, branch targets and conditions in; uPC and stack status out.
// master drives the control side, slave is the sequencer itself.
interface microsequencer_stack_if #(
  parameter int unsigned AW       = 9,
  parameter int unsigned NUM_COND = 4,
  parameter int unsigned CSW      = 2
);
  logic [2:0]          NS_Ctrl;
  logic [AW-1:0]       CR_Addr;
  logic [AW-1:0]       Decode_Addr;
  logic [NUM_COND-1:0] Cond_In;
  logic [CSW-1:0]      Cond_Sel;
  logic                Invert;
  logic                Stall;
  logic [AW-1:0]       uPC;
  logic [4:0]          Stack_Depth;
  logic                Stack_Overflow;
  logic                Stack_Underflow;

  modport master (
    output NS_Ctrl, CR_Addr, Decode_Addr, Cond_In, Cond_Sel, Invert, Stall,
    input  uPC, Stack_Depth, Stack_Overflow, Stack_Underflow
  );

  modport slave (
    input  NS_Ctrl, CR_Addr, Decode_Addr, Cond_In, Cond_Sel, Invert, Stall,
    output uPC, Stack_Depth, Stack_Overflow, Stack_Underflow
  );
endinterface

// File: rtl/microsequencer_stack.sv
// Next-address sequencer: registered uPC with increment/jump/decode/branch/wait modes and a
// hardware call/return stack with sticky overflow/underflow flags.
module microsequencer_stack #(
  parameter int unsigned AW          = 9,
  parameter int unsigned NUM_COND    = 4,
  parameter int unsigned CSW         = 2,
  parameter int unsigned STACK_DEPTH = 4,
  parameter int unsigned RESET_ADDR  = 0
) (
  input logic                  Clock,
  input logic                  Reset,
  microsequencer_stack_if.slave bus
);

  typedef enum logic [2:0] {
    NsInc, NsJump, NsDecode, NsCbr, NsCwait, NsCall, NsCcall, NsRet
  } ns_e;

  localparam int unsigned SPW      = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [4:0]  MaxDepth = 5'(STACK_DEPTH);
  localparam logic [AW-1:0] ResetAddr = AW'(RESET_ADDR);

  logic [AW-1:0]  upc_q, upc_d;
  logic [4:0]     depth_q, depth_d;
  logic           ovf_q, ovf_d;
  logic           unf_q, unf_d;
  logic [AW-1:0]  stack_q [STACK_DEPTH];
  logic [AW-1:0]  inc;
  logic [SPW-1:0] wr_idx, rd_idx;
  logic [2**CSW-1:0] cond_pad;
  logic           cond;
  logic           push;
  ns_e            mode;

  // Unused select codes read as 0 before inversion.
  always_comb begin
    cond_pad = '0;
    cond_pad[NUM_COND-1:0] = bus.Cond_In;
    cond = cond_pad[bus.Cond_Sel] ^ bus.Invert;
  end

  assign inc    = upc_q + AW'(1);
  assign wr_idx = depth_q[SPW-1:0];
  assign rd_idx = wr_idx - SPW'(1);
  assign mode   = ns_e'(bus.NS_Ctrl);

  always_comb begin
    upc_d   = upc_q;
    depth_d = depth_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    push    = 1'b0;
    if (!bus.Stall) begin
      unique case (mode)
        NsInc:    upc_d = inc;
        NsJump:   upc_d = bus.CR_Addr;
        NsDecode: upc_d = bus.Decode_Addr;
        NsCbr:    upc_d = cond ? bus.CR_Addr : inc;
        NsCwait:  upc_d = cond ? inc : upc_q;
        NsCall, NsCcall: begin
          if (mode == NsCall || cond) begin
            upc_d = bus.CR_Addr;
            // A full stack still takes the jump; only the return address is lost.
            if (depth_q == MaxDepth) begin
              ovf_d = 1'b1;
            end else begin
              push    = 1'b1;
              depth_d = depth_q + 5'd1;
            end
          end else begin
            upc_d = inc;
          end
        end
        NsRet: begin
          if (depth_q == 5'd0) begin
            upc_d = ResetAddr;
            unf_d = 1'b1;
          end else begin
            upc_d   = stack_q[rd_idx];
            depth_d = depth_q - 5'd1;
          end
        end
        default: upc_d = inc;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      upc_q   <= ResetAddr;
      depth_q <= 5'd0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      upc_q   <= upc_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset && push) begin
      stack_q[wr_idx] <= inc;
    end
  end

  assign bus.uPC             = upc_q;
  assign bus.Stack_Depth     = depth_q;
  assign bus.Stack_Overflow  = ovf_q;
  assign bus.Stack_Underflow = unf_q;

endmodule

// File: tb/tb_microsequencer_stack.sv
// Directed bench for microsequencer_stack: linear stimulus with hand-computed expectations.
module tb_microsequencer_stack;

  logic Clock = 1'b0;
  logic Reset;
  int   n_cmp = 0;
  int   n_err = 0;

  microsequencer_stack_if #(.AW(9), .NUM_COND(4), .CSW(2)) bus ();

  microsequencer_stack #(
    .AW(9), .NUM_COND(4), .CSW(2), .STACK_DEPTH(4), .RESET_ADDR(0)
  ) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int upc, input int dep, input int ovf,
                         input int unf);
    chk({tag, ".uPC"}, 32'(bus.uPC), 32'(upc));
    chk({tag, ".depth"}, 32'(bus.Stack_Depth), 32'(dep));
    chk({tag, ".ovf"}, 32'(bus.Stack_Overflow), 32'(ovf));
    chk({tag, ".unf"}, 32'(bus.Stack_Underflow), 32'(unf));
  endtask

  task automatic op(input logic [2:0] ns, input int cr);
    bus.NS_Ctrl = ns;
    bus.CR_Addr = 9'(cr);
    tick();
  endtask

  initial begin
    Reset = 1'b1;
    bus.NS_Ctrl = 3'd0; bus.CR_Addr = '0; bus.Decode_Addr = '0;
    bus.Cond_In = '0; bus.Cond_Sel = '0; bus.Invert = 1'b0; bus.Stall = 1'b0;
    tick();
    chk_all("reset", 0, 0, 0, 0);
    Reset = 1'b0;

    // Increment sequence and wrap
    op(3'd0, 0); chk("inc1", 32'(bus.uPC), 1);
    op(3'd0, 0); chk("inc2", 32'(bus.uPC), 2);
    op(3'd0, 0); chk("inc3", 32'(bus.uPC), 3);
    op(3'd1, 511); chk("jump511", 32'(bus.uPC), 511);
    op(3'd0, 0); chk("wrap", 32'(bus.uPC), 0);

    // Conditional branch, taken then inverted
    op(3'd1, 10);
    bus.Cond_Sel = 2'd1; bus.Cond_In = 4'b0010; bus.Invert = 1'b0;
    op(3'd3, 200); chk("cbr_taken", 32'(bus.uPC), 200);
    op(3'd1, 10);
    bus.Invert = 1'b1;
    op(3'd3, 200); chk("cbr_inv", 32'(bus.uPC), 11);
    bus.Invert = 1'b0;

    // Wait on MOC
    op(3'd1, 50);
    bus.Cond_Sel = 2'd0; bus.Cond_In = 4'b0000;
    op(3'd4, 0); chk("cwait1", 32'(bus.uPC), 50);
    op(3'd4, 0); chk("cwait2", 32'(bus.uPC), 50);
    op(3'd4, 0); chk("cwait3", 32'(bus.uPC), 50);
    bus.Cond_In = 4'b0001;
    op(3'd4, 0); chk("cwait_go", 32'(bus.uPC), 51);

    // Simple call/return
    op(3'd1, 20);
    op(3'd5, 100); chk_all("call", 100, 1, 0, 0);
    op(3'd0, 0); op(3'd0, 0); chk("sub_inc", 32'(bus.uPC), 102);
    op(3'd7, 0); chk_all("ret", 21, 0, 0, 0);

    // Nesting to overflow, then unwinding past empty
    op(3'd1, 20);
    op(3'd5, 100); op(3'd5, 110); op(3'd5, 120);
    op(3'd5, 130); chk_all("call4", 130, 4, 0, 0);
    op(3'd5, 140); chk_all("call5_ovf", 140, 4, 1, 0);
    op(3'd7, 0); chk_all("ret1", 121, 3, 1, 0);
    op(3'd7, 0); chk_all("ret2", 111, 2, 1, 0);
    op(3'd7, 0); chk_all("ret3", 101, 1, 1, 0);
    op(3'd7, 0); chk_all("ret4", 21, 0, 1, 0);
    op(3'd7, 0); chk_all("ret5_unf", 0, 0, 1, 1);

    // Reset clears flags; conditional call and decode
    Reset = 1'b1; tick(); Reset = 1'b0;
    chk_all("reset2", 0, 0, 0, 0);
    op(3'd1, 30);
    bus.Cond_Sel = 2'd2; bus.Cond_In = 4'b0000; bus.Invert = 1'b0;
    op(3'd6, 300); chk_all("ccall_no", 31, 0, 0, 0);
    bus.Invert = 1'b1;
    op(3'd6, 300); chk_all("ccall_yes", 300, 1, 0, 0);
    bus.Invert = 1'b0;
    bus.Decode_Addr = 9'd77;
    op(3'd2, 0); chk("decode", 32'(bus.uPC), 77);
    op(3'd7, 0); chk_all("ccall_ret", 32, 0, 0, 0);
    op(3'd7, 0); chk_all("unf_again", 0, 0, 0, 1);

    // Stall freezes everything; reset overrides stall mid-subroutine
    op(3'd1, 32);
    op(3'd5, 100); op(3'd5, 200); chk_all("pre_stall", 200, 2, 0, 1);
    bus.Stall = 1'b1;
    op(3'd5, 300); chk_all("stall_call", 200, 2, 0, 1);
    op(3'd7, 0); chk_all("stall_ret", 200, 2, 0, 1);
    Reset = 1'b1;
    op(3'd5, 300); chk_all("reset_stall", 0, 0, 0, 0);
    Reset = 1'b0; bus.Stall = 1'b0;
    op(3'd7, 0); chk_all("ret_after_reset", 0, 0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
